// File: rtl/fifo_read_dispatch_if.sv
// Bus bundle between the FIFO-select requester / FIFO bank / downstream sink
// and the read dispatcher. The dispatcher takes the master modport.
interface fifo_read_dispatch_if #(
    parameter int unsigned PORT_NUM = 32,
    parameter int unsigned DATA_W   = 32
);
    logic [7:0]                 fifo_sel_code;
    logic [PORT_NUM-1:0]        fifo_empty;
    logic [PORT_NUM*DATA_W-1:0] fifo_rdata;
    logic [PORT_NUM-1:0]        fifo_rd_en;
    logic [PORT_NUM-1:0]        fifo_done;
    logic [DATA_W-1:0]          out_data;
    logic                       out_valid;
    logic                       out_sop;
    logic                       out_eop;
    logic                       out_ready;
    logic                       busy;

    modport master (
        input  fifo_sel_code, fifo_empty, fifo_rdata, out_ready,
        output fifo_rd_en, fifo_done, out_data, out_valid, out_sop, out_eop, busy
    );

    modport slave (
        output fifo_sel_code, fifo_empty, fifo_rdata, out_ready,
        input  fifo_rd_en, fifo_done, out_data, out_valid, out_sop, out_eop, busy
    );
endinterface

// File: rtl/fifo_read_dispatch.sv
// Pops one length-prefixed packet from the show-ahead FIFO named by the select
// code and streams it through a one-word registered valid/ready output stage.
module fifo_read_dispatch #(
    parameter int unsigned PORT_NUM = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned LEN_W    = 12
) (
    input  logic                 glb_clk,
    input  logic                 glb_areset_n,
    fifo_read_dispatch_if.master bus
);
    localparam int unsigned IDX_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   out_data_q;
    logic                out_valid_q;
    logic                out_sop_q;
    logic                out_eop_q;
    logic                busy_q;
    logic [PORT_NUM-1:0] done_q;

    logic                sel_empty_c;
    logic [DATA_W-1:0]   sel_data_c;
    logic [PORT_NUM-1:0] sel_hot_c;
    logic [LEN_W-1:0]    hdr_len_c;
    logic [LEN_W-1:0]    eff_len_c;
    logic                code_ok_c;
    logic                load_c;
    logic                last_c;
    logic                unused_code_bits_c;

    // Select the latched FIFO's empty flag and head word; build its one-hot.
    always_comb begin
        sel_empty_c = 1'b1;
        sel_data_c  = '0;
        sel_hot_c   = '0;
        for (int i = 0; i < int'(PORT_NUM); i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_empty_c  = bus.fifo_empty[i];
                sel_data_c   = bus.fifo_rdata[i*int'(DATA_W) +: DATA_W];
                sel_hot_c[i] = 1'b1;
            end
        end
    end

    // Pop decision; the header's length is used directly on the first pop.
    always_comb begin
        hdr_len_c = (sel_data_c[LEN_W-1:0] == '0) ? LEN_W'(1) : sel_data_c[LEN_W-1:0];
        eff_len_c = (cnt_q == '0) ? hdr_len_c : len_q;
        code_ok_c = bus.fifo_sel_code[7] && (32'(bus.fifo_sel_code[IDX_W-1:0]) < PORT_NUM);
        load_c    = (state_q == ST_XFER) && !sel_empty_c
                    && (!out_valid_q || bus.out_ready) && (cnt_q < eff_len_c);
        last_c    = ((cnt_q + LEN_W'(1)) == eff_len_c);
    end

    assign unused_code_bits_c = ^bus.fifo_sel_code[6:IDX_W];

    assign bus.fifo_rd_en = load_c ? sel_hot_c : '0;
    assign bus.fifo_done  = done_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_sop    = out_sop_q;
    assign bus.out_eop    = out_eop_q;
    assign bus.busy       = busy_q;

    // Packet sequencer and registered output stage.
    always_ff @(posedge glb_clk or negedge glb_areset_n) begin
        if (!glb_areset_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= '0;
        end else begin
            done_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (code_ok_c) begin
                        idx_q   <= bus.fifo_sel_code[IDX_W-1:0];
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (load_c) begin
                        out_data_q  <= sel_data_c;
                        out_valid_q <= 1'b1;
                        out_sop_q   <= (cnt_q == '0);
                        out_eop_q   <= last_c;
                        cnt_q       <= cnt_q + LEN_W'(1);
                        if (cnt_q == '0) begin
                            len_q <= hdr_len_c;
                        end
                        if (last_c) begin
                            state_q <= ST_DRAIN;
                        end
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        out_sop_q   <= 1'b0;
                        out_eop_q   <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (!out_valid_q || bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        out_sop_q   <= 1'b0;
                        out_eop_q   <= 1'b0;
                        done_q      <= sel_hot_c;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
